// File: rtl/ram_word_port_if.sv
// Word request/response bundle between a memory master and ram_word_port.
interface ram_word_port_if #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_BYTES = 4
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [1:0]                req_size;
    logic [8*DATA_BYTES-1:0]   req_wdata;
    logic                      resp_valid;
    logic [8*DATA_BYTES-1:0]   resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/ram_word_port.sv
// Word-request front end over a byte-wide synchronous RAM: sequences 1/2/4-byte
// accesses one byte per cycle and returns a single completion pulse.
module ram_word_port #(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    ram_word_port_if.slave  bus
);
    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned CW = $clog2(DATA_BYTES + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  we_r;
    logic [CW-1:0]         nbytes;
    logic [CW-1:0]         n_req;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cap_idx;
    logic [DW-1:0]         wdata_r;
    logic [DW-1:0]         rdata_r;
    logic [7:0]            wbyte;
    logic [7:0]            ram_q;
    logic                  accept;
    logic                  last;
    logic                  ready;
    logic                  resp_valid;
    logic                  cap_en;

    logic [7:0] mem [2**ADDR_WIDTH];

    // Size 3 and sizes wider than the bus both clamp to DATA_BYTES.
    always_comb begin
        int unsigned n;
        n = 32'd1 << bus.req_size;
        if (n > DATA_BYTES) n = DATA_BYTES;
        n_req = CW'(n);
    end

    assign accept   = bus.req_valid & ready;
    assign last     = (cnt == nbytes - CW'(1));
    assign ram_addr = base + ADDR_WIDTH'(cnt);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid) state_nxt = ACCESS;
            end
            ACCESS: if (last) state_nxt = we_r ? RESP : DRAIN;
            DRAIN:  state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered RAM output lags the address by one cycle, so the byte read in
    // cycle k lands in rdata during cycle k+1 (the final one during DRAIN).
    assign cap_en  = !we_r && ((state == ACCESS && cnt != '0) || state == DRAIN);
    assign cap_idx = cnt - CW'(1);

    always_comb begin
        wbyte = '0;
        for (int unsigned b = 0; b < DATA_BYTES; b++)
            if (cnt == CW'(b)) wbyte = wdata_r[b*8 +: 8];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            base    <= '0;
            we_r    <= 1'b0;
            nbytes  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                base    <= bus.req_addr;
                we_r    <= bus.req_we;
                nbytes  <= n_req;
                wdata_r <= bus.req_wdata;
                if (!bus.req_we) rdata_r <= '0;
            end
            cnt <= (state == ACCESS) ? cnt + CW'(1) : '0;
            if (cap_en) begin
                for (int unsigned b = 0; b < DATA_BYTES; b++)
                    if (cap_idx == CW'(b)) rdata_r[b*8 +: 8] <= ram_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (state == ACCESS) begin
            if (we_r) mem[ram_addr] <= wbyte;
            else      ram_q         <= mem[ram_addr];
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_r;
endmodule

// File: tb/tb_ram_word_port.sv
// Scoreboard bench for ram_word_port: driver queues hand-computed responses,
// a negedge monitor pops and compares data and latency on every resp_valid.
module tb_ram_word_port;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_word_port_if #(.ADDR_WIDTH(17), .DATA_BYTES(4)) bus ();

    ram_word_port #(.ADDR_WIDTH(17), .DATA_BYTES(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        longint      t_acc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;
    int   mon_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency counts whole cycles from the accept edge to the resp_valid cycle.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got resp_valid=1 expected no response");
            end else begin
                mon_e   = sb.pop_front();
                mon_lat = int'((longint'($time) - mon_e.t_acc - 5) / 10);
                chk($sformatf("lat_%0d", mon_e.id), mon_lat, mon_e.lat);
                chk($sformatf("rdata_%0d", mon_e.id), bus.resp_rdata, mon_e.rdata);
            end
        end
    end

    task automatic issue(input int id, input logic we, input logic [16:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input int lat);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_size  = size;
        bus.req_wdata = wdata;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout_%0d: req_ready=%b expected 1", id, bus.req_ready);
        end else begin
            e.rdata = exp_rdata;
            e.lat   = lat;
            e.t_acc = longint'($time) + 5;
            e.id    = id;
            sb.push_back(e);
            @(posedge clk);
        end
    endtask

    task automatic drain();
        int n;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 17'($urandom);
        bus.req_size  = 2'($urandom);
        bus.req_wdata = $urandom;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL resp_timeout: outstanding=%0d expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        rst_n = 1'b1;

        // 4-byte write/read and per-byte readback
        issue(1, 1'b1, 17'h00100, 2'd2, 32'hDEADBEEF, 32'h00000000, 4); drain();
        issue(2, 1'b0, 17'h00100, 2'd2, 32'h0,        32'hDEADBEEF, 5); drain();
        issue(3, 1'b0, 17'h00100, 2'd0, 32'h0,        32'h000000EF, 2); drain();
        issue(4, 1'b0, 17'h00101, 2'd0, 32'h0,        32'h000000BE, 2); drain();
        issue(5, 1'b0, 17'h00102, 2'd0, 32'h0,        32'h000000AD, 2); drain();
        issue(6, 1'b0, 17'h00103, 2'd0, 32'h0,        32'h000000DE, 2); drain();

        // address wrap from 0x1FFFF to 0x00000
        issue(7,  1'b1, 17'h1FFFF, 2'd1, 32'h0000CAFE, 32'h000000DE, 2); drain();
        issue(8,  1'b0, 17'h1FFFF, 2'd0, 32'h0,        32'h000000FE, 2); drain();
        issue(9,  1'b0, 17'h00000, 2'd0, 32'h0,        32'h000000CA, 2); drain();
        issue(10, 1'b0, 17'h1FFFF, 2'd1, 32'h0,        32'h0000CAFE, 3); drain();

        // partial read zero-fills upper bytes; ready low through resp cycle
        issue(11, 1'b1, 17'h00020, 2'd2, 32'h11223344, 32'h0000CAFE, 4); drain();
        issue(12, 1'b0, 17'h00022, 2'd0, 32'h0,        32'h00000022, 2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("busy_ready_c0", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("busy_ready_c1", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("busy_ready_resp", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);
        drain();

        // reserved size 3 behaves as 4 bytes
        issue(13, 1'b0, 17'h00100, 2'd3, 32'h0,        32'hDEADBEEF, 5); drain();
        issue(14, 1'b1, 17'h00200, 2'd3, 32'h01020304, 32'hDEADBEEF, 4); drain();
        issue(15, 1'b0, 17'h00200, 2'd2, 32'h0,        32'h01020304, 5); drain();

        // valid held high, inputs change while the previous request is busy
        issue(20, 1'b1, 17'h00300, 2'd1, 32'hFFFF5A6B, 32'h01020304, 2);
        issue(21, 1'b0, 17'h00300, 2'd1, 32'h0,        32'h00005A6B, 3);
        issue(22, 1'b1, 17'h00301, 2'd0, 32'h12345677, 32'h00005A6B, 1);
        issue(23, 1'b0, 17'h00300, 2'd1, 32'h0,        32'h0000776B, 3);
        issue(24, 1'b1, 17'h00304, 2'd2, 32'h89ABCDEF, 32'h0000776B, 4);
        issue(25, 1'b0, 17'h00304, 2'd2, 32'h0,        32'h89ABCDEF, 5);
        drain();

        // asynchronous reset while byte 2 of a write is in progress
        issue(30, 1'b1, 17'h00040, 2'd2, 32'hAABBCCDD, 32'h0, 4);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("arst_rdata", bus.resp_rdata, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(31, 1'b0, 17'h00040, 2'd1, 32'h0, 32'h0000CCDD, 3); drain();
        issue(32, 1'b0, 17'h00041, 2'd0, 32'h0, 32'h000000CC, 2); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
